iq_write: RTL and testbench

IQ_WRITE -- requirements
Module: iq_write

---
 rtl/iq_write.sv | 123 ++++++++++++
 tb/tb_iq_write.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_write.sv
// iq_write: accepts one fixed-point I/Q pair, dequantizes both components to
// 16-bit saturated integers, packs them into one word and writes it to a
// downstream FIFO. One pair in flight; IDLE -> PACK -> EMIT -> IDLE.
module iq_write #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned QUANTIZE_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dataAvailible,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic [DATA_WIDTH-1:0] q_data_in,
    output logic                  in_rd_en,
    input  logic                  out_full,
    output logic [DATA_WIDTH-1:0] iq_data_out,
    output logic                  out_wr_en,
    output logic [15:0]           sat_count
);

    // One extra bit so the rounding add cannot overflow.
    localparam int unsigned EXT_W = DATA_WIDTH + 1;
    localparam logic signed [EXT_W-1:0] ROUND_ADD = EXT_W'(2 ** (QUANTIZE_WIDTH - 1));
    localparam logic signed [EXT_W-1:0] SAT_MAX   = EXT_W'(32767);
    localparam logic signed [EXT_W-1:0] SAT_MIN   = -EXT_W'(32768);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PACK = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_i_hold;
    logic [DATA_WIDTH-1:0] r_q_hold;
    logic [DATA_WIDTH-1:0] r_iq_data;
    logic [15:0]           r_sat_count;

    logic [16:0]           w_i_deq;
    logic [16:0]           w_q_deq;
    logic [DATA_WIDTH-1:0] w_packed;
    logic [16:0]           w_sat_sum;
    logic [15:0]           w_sat_next;

    // Round-half-up, arithmetic shift, clamp to int16. Bit 16 flags a clamp.
    function automatic logic [16:0] dequant(input logic [DATA_WIDTH-1:0] x);
        logic signed [EXT_W-1:0] v_ext;
        logic signed [EXT_W-1:0] v_shr;
        logic [16:0]             v_res;
        v_ext = signed'({x[DATA_WIDTH-1], x});
        v_shr = (v_ext + ROUND_ADD) >>> QUANTIZE_WIDTH;
        if (v_shr > SAT_MAX) begin
            v_res = {1'b1, 16'h7FFF};
        end else if (v_shr < SAT_MIN) begin
            v_res = {1'b1, 16'h8000};
        end else begin
            v_res = {1'b0, v_shr[15:0]};
        end
        return v_res;
    endfunction

    assign w_i_deq    = dequant(r_i_hold);
    assign w_q_deq    = dequant(r_q_hold);
    assign w_packed   = DATA_WIDTH'({w_q_deq[15:0], w_i_deq[15:0]});
    assign w_sat_sum  = {1'b0, r_sat_count} + 17'(w_i_deq[16]) + 17'(w_q_deq[16]);
    assign w_sat_next = w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];

    assign iq_data_out = r_iq_data;
    assign sat_count   = r_sat_count;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (dataAvailible) w_state_next = S_PACK;
            S_PACK:  w_state_next = S_EMIT;
            S_EMIT:  if (!out_full) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake strobes; both forced low while reset is held.
    always_comb begin
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE:  in_rd_en  = dataAvailible;
                S_EMIT:  out_wr_en = !out_full;
                default: ;
            endcase
        end
    end

    // Capture the pair on accept; update output word and clamp count in PACK.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_i_hold    <= '0;
            r_q_hold    <= '0;
            r_iq_data   <= '0;
            r_sat_count <= '0;
        end else begin
            if (in_rd_en) begin
                r_i_hold <= i_data_in;
                r_q_hold <= q_data_in;
            end
            if (r_state == S_PACK) begin
                r_iq_data   <= w_packed;
                r_sat_count <= w_sat_next;
            end
        end
    end

endmodule

// File: tb/tb_iq_write.sv
// Bench for iq_write: directed vector table, hand-written corner sequences,
// and a randomized run scored by a cycle monitor against a reference model.
module tb_iq_write;

    logic        clock;
    logic        reset;
    logic        dataAvailible;
    logic [31:0] i_data_in;
    logic [31:0] q_data_in;
    logic        in_rd_en;
    logic        out_full;
    logic [31:0] iq_data_out;
    logic        out_wr_en;
    logic [15:0] sat_count;

    iq_write #(.DATA_WIDTH(32), .QUANTIZE_WIDTH(10)) dut (
        .clock         (clock),
        .reset         (reset),
        .dataAvailible (dataAvailible),
        .i_data_in     (i_data_in),
        .q_data_in     (q_data_in),
        .in_rd_en      (in_rd_en),
        .out_full      (out_full),
        .iq_data_out   (iq_data_out),
        .out_wr_en     (out_wr_en),
        .sat_count     (sat_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] word;
        int          nclamp;
    } exp_t;

    typedef struct {
        logic [31:0] i;
        logic [31:0] q;
        logic [31:0] word;
        int          inc;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   tb_sat   = 0;

    exp_t        sb[$];
    int          cyc_n     = 0;
    int          acc_cyc   = 0;
    int          n_writes  = 0;
    int          model_sat = 0;
    logic [31:0] last_word = 32'h0;
    bit          mon_en    = 1'b0;
    bit          m_idle;
    exp_t        m_e;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference: floor((x + 512) / 1024) in real arithmetic.
    function automatic int deq_raw(input logic [31:0] x);
        real v;
        v = $floor(($itor($signed(x)) + 512.0) / 1024.0);
        return $rtoi(v);
    endfunction

    function automatic logic [15:0] clamp16(input int r);
        if (r > 32767)  return 16'h7FFF;
        if (r < -32768) return 16'h8000;
        return 16'(r);
    endfunction

    function automatic exp_t model_pair(input logic [31:0] vi, input logic [31:0] vq);
        exp_t e;
        int   ri;
        int   rq;
        ri = deq_raw(vi);
        rq = deq_raw(vq);
        e.word   = {clamp16(rq), clamp16(ri)};
        e.nclamp = ((ri > 32767 || ri < -32768) ? 1 : 0) + ((rq > 32767 || rq < -32768) ? 1 : 0);
        return e;
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > 65535) ? 65535 : a + b;
    endfunction

    function automatic logic [31:0] rnd_sample();
        logic [31:0] edges [6];
        int unsigned m;
        int          v;
        edges[0] = 32'h01FFFDFF; edges[1] = 32'h01FFFE00; edges[2] = 32'hFDFFFE00;
        edges[3] = 32'hFDFFFDFF; edges[4] = 32'h7FFFFFFF; edges[5] = 32'h80000000;
        m = $urandom_range(0, 3);
        case (m)
            0: return $urandom;
            1: begin
                v = int'($urandom_range(0, 32'h0800_0000)) - 32'sh0400_0000;
                return 32'(v);
            end
            2: return edges[$urandom_range(0, 5)];
            default: begin
                v = (int'($urandom_range(0, 4096)) - 2048) * 1024 + 512 + int'($urandom_range(0, 2)) - 1;
                return 32'(v);
            end
        endcase
    endfunction

    // Cycle monitor: scoreboards every written word, latency, holding and strobes.
    always @(negedge clock) begin
        if (mon_en) begin
            cyc_n = cyc_n + 1;
            if (reset) begin
                chk("mon_rst_rd_en", 32'(in_rd_en), 32'h0);
                chk("mon_rst_wr_en", 32'(out_wr_en), 32'h0);
                sb.delete();
                model_sat = 0;
                last_word = 32'h0;
            end else begin
                m_idle = (sb.size() == 0);
                if (!m_idle && (cyc_n - acc_cyc) >= 2) begin
                    chk("mon_emit_word", iq_data_out, sb[0].word);
                    chk("mon_emit_wr_en", 32'(out_wr_en), 32'(!out_full));
                    if (out_wr_en) begin
                        m_e       = sb.pop_front();
                        model_sat = sat_add(model_sat, m_e.nclamp);
                        chk("mon_sat_count", 32'(sat_count), 32'(model_sat));
                        last_word = m_e.word;
                        n_writes  = n_writes + 1;
                    end
                end else begin
                    chk("mon_idle_wr_en", 32'(out_wr_en), 32'h0);
                    chk("mon_word_hold", iq_data_out, last_word);
                end
                chk("mon_rd_en", 32'(in_rd_en), m_idle ? 32'(dataAvailible) : 32'h0);
                if (in_rd_en) begin
                    sb.push_back(model_pair(i_data_in, q_data_in));
                    acc_cyc = cyc_n;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One pair through the block with no backpressure; garbage inputs outside IDLE.
    task automatic apply_vec(input logic [31:0] vi, input logic [31:0] vq,
                             input logic [31:0] vw, input int inc, input string tag);
        dataAvailible = 1'b1;
        i_data_in     = vi;
        q_data_in     = vq;
        @(negedge clock);
        chk({tag, "_accept"}, 32'(in_rd_en), 32'h1);
        step();
        i_data_in = $urandom;
        q_data_in = $urandom;
        @(negedge clock);
        chk({tag, "_pack_rd"}, 32'(in_rd_en), 32'h0);
        chk({tag, "_pack_wr"}, 32'(out_wr_en), 32'h0);
        step();
        @(negedge clock);
        chk({tag, "_emit_wr"}, 32'(out_wr_en), 32'h1);
        chk({tag, "_word"}, iq_data_out, vw);
        tb_sat = sat_add(tb_sat, inc);
        chk({tag, "_sat"}, 32'(sat_count), 32'(tb_sat));
        chk({tag, "_emit_rd"}, 32'(in_rd_en), 32'h0);
        step();
        dataAvailible = 1'b0;
        @(negedge clock);
        chk({tag, "_after_wr"}, 32'(out_wr_en), 32'h0);
        chk({tag, "_after_word"}, iq_data_out, vw);
        step();
    endtask

    task automatic zero_check(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            chk({tag, "_wr"}, 32'(out_wr_en), 32'h0);
            chk({tag, "_word"}, iq_data_out, 32'h0);
            chk({tag, "_sat"}, 32'(sat_count), 32'h0);
            step();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [8];
        int   base;
        int   budget;

        tbl[0] = '{32'h00000400, 32'hFFFFFC00, 32'hFFFF0001, 0};
        tbl[1] = '{32'h00000200, 32'h000001FF, 32'h00000001, 0};
        tbl[2] = '{32'hFFFFFE00, 32'hFFFFFDFF, 32'hFFFF0000, 0};
        tbl[3] = '{32'h7FFFFFFF, 32'h80000000, 32'h80007FFF, 2};
        tbl[4] = '{32'h01FFFDFF, 32'hFDFFFE00, 32'h80007FFF, 0};
        tbl[5] = '{32'h01FFFE00, 32'hFDFFFDFF, 32'h80007FFF, 2};
        tbl[6] = '{32'h00000000, 32'h00000000, 32'h00000000, 0};
        tbl[7] = '{32'h00000BFF, 32'hFFFFF400, 32'hFFFD0003, 0};

        reset         = 1'b1;
        dataAvailible = 1'b1;
        out_full      = 1'b0;
        i_data_in     = 32'h00000400;
        q_data_in     = 32'h00000400;
        mon_en        = 1'b1;

        // Reset state and strobe masking.
        repeat (2) begin
            @(negedge clock);
            chk("rst_rd_en", 32'(in_rd_en), 32'h0);
            chk("rst_wr_en", 32'(out_wr_en), 32'h0);
        end
        chk("rst_word", iq_data_out, 32'h0);
        chk("rst_sat", 32'(sat_count), 32'h0);
        step();
        reset         = 1'b0;
        dataAvailible = 1'b0;
        step();

        // Directed vectors.
        tb_sat = 0;
        for (int k = 0; k < 8; k++) begin
            apply_vec(tbl[k].i, tbl[k].q, tbl[k].word, tbl[k].inc, $sformatf("vec%0d", k));
        end

        // Backpressure: five full cycles in EMIT, then a single write.
        dataAvailible = 1'b1;
        i_data_in     = 32'h00012345;
        q_data_in     = 32'hFFFE0000;
        out_full      = 1'b1;
        @(negedge clock);
        chk("bp_accept", 32'(in_rd_en), 32'h1);
        step();
        dataAvailible = 1'b0;
        @(negedge clock);
        chk("bp_pack_wr", 32'(out_wr_en), 32'h0);
        step();
        repeat (5) begin
            dataAvailible = 1'b1;
            i_data_in     = $urandom;
            q_data_in     = $urandom;
            @(negedge clock);
            chk("bp_full_wr", 32'(out_wr_en), 32'h0);
            chk("bp_full_rd", 32'(in_rd_en), 32'h0);
            chk("bp_full_word", iq_data_out, 32'hFF800049);
            step();
        end
        out_full      = 1'b0;
        dataAvailible = 1'b0;
        @(negedge clock);
        chk("bp_release_wr", 32'(out_wr_en), 32'h1);
        chk("bp_release_word", iq_data_out, 32'hFF800049);
        step();
        @(negedge clock);
        chk("bp_single_pulse", 32'(out_wr_en), 32'h0);
        step();

        // Reset while the pair sits in PACK.
        dataAvailible = 1'b1;
        i_data_in     = 32'h7FFFFFFF;
        q_data_in     = 32'h80000000;
        @(negedge clock);
        chk("rpack_accept", 32'(in_rd_en), 32'h1);
        step();
        dataAvailible = 1'b0;
        reset         = 1'b1;
        @(negedge clock);
        chk("rpack_rd", 32'(in_rd_en), 32'h0);
        chk("rpack_wr", 32'(out_wr_en), 32'h0);
        step();
        reset = 1'b0;
        zero_check("rpack_after", 3);

        // Reset while the pair sits in EMIT with the FIFO ready.
        dataAvailible = 1'b1;
        @(negedge clock);
        chk("remit_accept", 32'(in_rd_en), 32'h1);
        step();
        dataAvailible = 1'b0;
        step();
        reset    = 1'b1;
        out_full = 1'b0;
        @(negedge clock);
        chk("remit_wr", 32'(out_wr_en), 32'h0);
        chk("remit_rd", 32'(in_rd_en), 32'h0);
        step();
        reset = 1'b0;
        zero_check("remit_after", 3);
        tb_sat = 0;
        apply_vec(tbl[3].i, tbl[3].q, tbl[3].word, tbl[3].inc, "post_rst_a");
        apply_vec(tbl[0].i, tbl[0].q, tbl[0].word, tbl[0].inc, "post_rst_b");

        // Randomized traffic with backpressure and occasional reset.
        for (int c = 0; c < 400; c++) begin
            dataAvailible = ($urandom_range(0, 9) < 6);
            out_full      = ($urandom_range(0, 9) < 3);
            reset         = ($urandom_range(0, 99) == 0);
            i_data_in     = rnd_sample();
            q_data_in     = rnd_sample();
            step();
        end
        reset         = 1'b0;
        out_full      = 1'b0;
        dataAvailible = 1'b0;
        repeat (6) step();
        chk("rand_drain", 32'(sb.size()), 32'h0);

        // Saturation counter sticks at 0xFFFF after 32768 double clamps.
        reset = 1'b1;
        step();
        reset         = 1'b0;
        dataAvailible = 1'b1;
        i_data_in     = 32'h7FFFFFFF;
        q_data_in     = 32'h80000000;
        base          = n_writes;
        budget        = 0;
        while ((n_writes - base) < 32768 && budget < 32768 * 3 + 50) begin
            step();
            budget = budget + 1;
        end
        chk("sat_pairs", 32'(n_writes - base), 32'd32768);
        chk("sat_stick", 32'(sat_count), 32'h0000FFFF);
        repeat (12) step();
        chk("sat_hold", 32'(sat_count), 32'h0000FFFF);
        dataAvailible = 1'b0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
